// File: rtl/mod_mul_pkg.sv
// Shared types and constants for the sequential GF(191) multiplier.
package mod_mul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    localparam int unsigned W_DEF = 8;
    localparam int unsigned P_DEF = 191;
    localparam int unsigned PW    = 2 * W_DEF;

endpackage

// File: rtl/mod_mul_datapath.sv
// Shift-and-add datapath: accumulator, shifted multiplicand, multiplier and
// iteration counter. One multiplier bit is consumed per step.
module mod_mul_datapath
    import mod_mul_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           last_o,
    output logic [2*W-1:0] acc_nxt_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] mcand_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] acc_nxt;

    // Partial-product add for the current multiplier bit; cannot overflow 2*W bits.
    always_comb begin
        acc_nxt = acc_q;
        if (mplier_q[0]) begin
            acc_nxt = acc_q + mcand_q;
        end
    end

    assign acc_nxt_o = acc_nxt;
    assign last_o    = step_i && (cnt_q == CW'(W - 1));

    // Operand load on acceptance, then one shift/accumulate per busy cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            acc_q    <= acc_nxt;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mod_mul_seq_191.sv
// Sequential shift-and-add multiplier producing the full 2*W-bit product a*b
// over valid/ready handshakes. Fixed latency of W iterations.
// Optional operand range check enabled by defining MOD_MUL_RANGE_CHECK_EN.
module mod_mul_seq_191
    import mod_mul_pkg::*;
#(
    parameter int unsigned W = W_DEF,
    parameter int unsigned P = P_DEF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*W-1:0] product_o,
    output logic           busy_o,
    output logic           err_o
);

    state_e         state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           busy_q;
    logic [2*W-1:0] product_q;

    logic           accept;
    logic           out_fire;
    logic           last;
    logic [2*W-1:0] acc_nxt;
    logic           err_flag;

    assign accept   = (state_q == StIdle) && in_valid_i;
    assign out_fire = (state_q == StDone) && out_ready_i;

    mod_mul_datapath #(
        .W (W)
    ) u_datapath (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (accept),
        .step_i    (state_q == StBusy),
        .a_i       (a_i),
        .b_i       (b_i),
        .last_o    (last),
        .acc_nxt_o (acc_nxt)
    );

`ifdef MOD_MUL_RANGE_CHECK_EN
    logic err_flag_q;
    logic range_err;

    assign range_err = (32'(a_i) >= P) || (32'(b_i) >= P);

    // Capture out-of-field operands at acceptance; cleared by the output handshake.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_flag_q <= 1'b0;
        end else if (accept) begin
            err_flag_q <= range_err;
        end else if (out_fire) begin
            err_flag_q <= 1'b0;
        end
    end

    assign err_flag = err_flag_q;
    assign err_o    = err_flag_q & out_valid_q;
`else
    logic unused_p;

    assign unused_p = ^(32'(P));
    assign err_flag = 1'b0;
    assign err_o    = 1'b0;
`endif

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            product_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        state_q    <= StBusy;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                StBusy: begin
                    if (last) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        product_q   <= err_flag ? '0 : acc_nxt;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign product_o   = product_q;

endmodule

// File: tb/tb_mod_mul_seq_191.sv
// Self-checking bench for mod_mul_seq_191 with a scoreboard of expected
// {err, product} entries pushed on acceptance and popped on output handshake.
module tb_mod_mul_seq_191;

    localparam int unsigned W = 8;
    localparam int unsigned P = 191;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] product;
    logic           busy;
    logic           err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [2*W:0] exp_q[$];

    mod_mul_seq_191 #(
        .W (W),
        .P (P)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .product_o   (product),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        logic           e;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        e = 1'b0;
`ifdef MOD_MUL_RANGE_CHECK_EN
        if (32'(x) >= P || 32'(y) >= P) begin
            e = 1'b1;
            p = '0;
        end
`endif
        return {e, p};
    endfunction

    // Pop the oldest expectation and compare it with the presented output.
    task automatic pop_check(input string tag);
        logic [2*W:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_product"}, 32'(product), 32'(e[2*W-1:0]));
            check({tag, "_err"}, 32'(err), 32'(e[2*W]));
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        exp_q.push_back(model(x, y));
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(W));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            if (exp_q.size() != 0) begin
                check({tag, "_hold_product"}, 32'(product), 32'(exp_q[0][2*W-1:0]));
            end
            tick();
        end
        out_ready = 1'b1;
        pop_check(tag);
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    // Two operand pairs with in_valid held high and out_ready high.
    task automatic back_to_back();
        int   got;
        int   acc;
        int   acc_cyc[2];
        logic fire_in;
        logic fire_out;
        got        = 0;
        acc        = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        a          = 8'd1;
        b          = 8'd190;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        for (int i = 0; i < 60 && got < 2; i++) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                pop_check("b2b");
                got++;
            end
            tick();
            if (fire_in) begin
                exp_q.push_back(model(a, b));
                if (acc < 2) acc_cyc[acc] = cyc;
                acc++;
                if (acc == 1) begin
                    a = 8'd190;
                    b = 8'd1;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_outputs", 32'(got), 32'd2);
        check("b2b_accepts", 32'(acc), 32'd2);
        check("b2b_ii", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("zero", 8'd0, 8'd0, 0);
        do_op("max_field", 8'd190, 8'd190, 0);
        back_to_back();
        do_op("stall", 8'd13, 8'd17, 5);

        // Abandon an operation mid-iteration with a one-cycle reset.
        a        = 8'd100;
        b        = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        repeat (W + 2) begin
            tick();
            check("midrst_no_output", 32'(out_valid), 32'd0);
        end
        do_op("after_rst", 8'd2, 8'd3, 0);

        do_op("range", 8'd200, 8'd3, 1);
        do_op("all_ones", 8'hFF, 8'hFF, 0);
        for (int i = 0; i < 4; i++) begin
            do_op("rand", W'($urandom_range(0, 190)), W'($urandom_range(0, 190)), i);
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
